// File: rtl/uart_hex_cmd_parser_pkg.sv
// Shared types and constants for the UART hex command parser.
// Optional echo path selected by macro UART_CMD_ECHO_EN.
package uart_cmd_pkg;

  localparam int NIBBLE_BITS = 4;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_9    = 8'h39;
  localparam logic [7:0] ASCII_UC_A = 8'h41;
  localparam logic [7:0] ASCII_UC_F = 8'h46;
  localparam logic [7:0] ASCII_LC_A = 8'h61;
  localparam logic [7:0] ASCII_LC_F = 8'h66;

`ifdef UART_CMD_ECHO_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_ECHO   = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1
  } state_t;
`endif

endpackage

// File: rtl/uart_hex_cmd_parser_if.sv
// Bus between the command parser and the UART FIFOs / consumer.
// master = parser side, slave = UART / consumer side.
interface uart_hex_cmd_parser_if #(
  parameter int DATA_BITS    = 8,
  parameter int VALUE_DIGITS = 4
);
  logic                      RxEmpty;
  logic [DATA_BITS-1:0]      ReadData;
  logic                      ReadUart;
  logic                      TxFull;
  logic                      WriteUart;
  logic [DATA_BITS-1:0]      WriteData;
  logic [4*VALUE_DIGITS-1:0] Value;
  logic                      ValueValid;
  logic                      Error;

  modport master (
    input  RxEmpty, ReadData, TxFull,
    output ReadUart, WriteUart, WriteData, Value, ValueValid, Error
  );

  modport slave (
    output RxEmpty, ReadData, TxFull,
    input  ReadUart, WriteUart, WriteData, Value, ValueValid, Error
  );
endinterface

// File: rtl/uart_hex_cmd_parser_classifier.sv
// Combinational ASCII classifier: hex digit / line terminator / other.
module ascii_hex_classifier
  import uart_cmd_pkg::*;
(
  input  logic [7:0]             Byte,
  output logic                   IsDigit,
  output logic                   IsTerm,
  output logic [NIBBLE_BITS-1:0] Nibble
);

  // Letters A-F/a-f have low nibble 1-6, so adding 9 yields 10-15
  always_comb begin
    IsDigit = 1'b0;
    IsTerm  = 1'b0;
    Nibble  = 4'h0;
    if (Byte >= ASCII_0 && Byte <= ASCII_9) begin
      IsDigit = 1'b1;
      Nibble  = Byte[3:0];
    end else if ((Byte >= ASCII_UC_A && Byte <= ASCII_UC_F) ||
                 (Byte >= ASCII_LC_A && Byte <= ASCII_LC_F)) begin
      IsDigit = 1'b1;
      Nibble  = Byte[3:0] + 4'd9;
    end else if (Byte == ASCII_CR || Byte == ASCII_LF) begin
      IsTerm  = 1'b1;
    end else begin
      IsDigit = 1'b0;
    end
  end

endmodule

// File: rtl/uart_hex_cmd_parser.sv
// UART hex command parser: pops RX bytes, accumulates hex digits and
// publishes the value on CR/LF. Echo to Tx compiled in by UART_CMD_ECHO_EN.
module uart_hex_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int VALUE_DIGITS = 4
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  uart_hex_cmd_parser_if.master bus
);

  localparam int VW         = NIBBLE_BITS * VALUE_DIGITS;
  localparam int COUNT_BITS = $clog2(VALUE_DIGITS + 1);
  localparam logic [COUNT_BITS-1:0] COUNT_MAX = COUNT_BITS'(VALUE_DIGITS);

  state_t                 state_r, state_nxt;
  logic [DATA_BITS-1:0]   byte_r, byte_nxt;
  logic [VW-1:0]          acc_r, acc_nxt;
  logic [COUNT_BITS-1:0]  count_r, count_nxt;
  logic                   discard_r, discard_nxt;
  logic                   read_uart_r, read_uart_nxt;
  logic [VW-1:0]          value_r, value_nxt;
  logic                   value_valid_r, value_valid_nxt;
  logic                   error_r, error_nxt;

  logic                   is_digit_s;
  logic                   is_term_s;
  logic [NIBBLE_BITS-1:0] nibble_s;

  ascii_hex_classifier u_classifier (
    .Byte    (byte_r),
    .IsDigit (is_digit_s),
    .IsTerm  (is_term_s),
    .Nibble  (nibble_s)
  );

`ifdef UART_CMD_ECHO_EN
  logic                 write_uart_r, write_uart_nxt;
  logic [DATA_BITS-1:0] write_data_r, write_data_nxt;
`endif

  // Next-state, accumulator and output-strobe logic
  always_comb begin
    state_nxt       = state_r;
    byte_nxt        = byte_r;
    acc_nxt         = acc_r;
    count_nxt       = count_r;
    discard_nxt     = discard_r;
    read_uart_nxt   = 1'b0;
    value_nxt       = value_r;
    value_valid_nxt = 1'b0;
    error_nxt       = 1'b0;
`ifdef UART_CMD_ECHO_EN
    write_uart_nxt  = 1'b0;
    write_data_nxt  = write_data_r;
`endif
    case (state_r)
      ST_IDLE: begin
        // Pop is issued as a registered strobe during DECODE, so the
        // next IDLE already sees the post-pop RxEmpty
        if (!bus.RxEmpty) begin
          byte_nxt      = bus.ReadData;
          read_uart_nxt = 1'b1;
          state_nxt     = ST_DECODE;
        end else begin
          state_nxt     = ST_IDLE;
        end
      end
      ST_DECODE: begin
        if (is_digit_s) begin
          if (discard_r) begin
            discard_nxt = 1'b1;
          end else if (count_r == COUNT_MAX) begin
            error_nxt   = 1'b1;
            discard_nxt = 1'b1;
            acc_nxt     = {VW{1'b0}};
            count_nxt   = {COUNT_BITS{1'b0}};
          end else begin
            acc_nxt   = {acc_r[VW-NIBBLE_BITS-1:0], nibble_s};
            count_nxt = count_r + COUNT_BITS'(1);
          end
        end else if (is_term_s) begin
          // Empty lines publish nothing, so CRLF gives a single value
          if (!discard_r && count_r != {COUNT_BITS{1'b0}}) begin
            value_nxt       = acc_r;
            value_valid_nxt = 1'b1;
          end else begin
            value_valid_nxt = 1'b0;
          end
          acc_nxt     = {VW{1'b0}};
          count_nxt   = {COUNT_BITS{1'b0}};
          discard_nxt = 1'b0;
        end else begin
          if (!discard_r) begin
            error_nxt = 1'b1;
          end else begin
            error_nxt = 1'b0;
          end
          discard_nxt = 1'b1;
          acc_nxt     = {VW{1'b0}};
          count_nxt   = {COUNT_BITS{1'b0}};
        end
`ifdef UART_CMD_ECHO_EN
        // Write is decided here so WriteUart can be a registered strobe
        // in the first ECHO cycle
        state_nxt      = ST_ECHO;
        write_data_nxt = byte_r;
        if (!bus.TxFull) begin
          write_uart_nxt = 1'b1;
        end else begin
          write_uart_nxt = 1'b0;
        end
`else
        state_nxt = ST_IDLE;
`endif
      end
`ifdef UART_CMD_ECHO_EN
      ST_ECHO: begin
        if (write_uart_r) begin
          state_nxt      = ST_IDLE;
        end else if (!bus.TxFull) begin
          write_uart_nxt = 1'b1;
        end else begin
          state_nxt      = ST_ECHO;
        end
      end
`endif
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_r       <= ST_IDLE;
      byte_r        <= {DATA_BITS{1'b0}};
      acc_r         <= {VW{1'b0}};
      count_r       <= {COUNT_BITS{1'b0}};
      discard_r     <= 1'b0;
      read_uart_r   <= 1'b0;
      value_r       <= {VW{1'b0}};
      value_valid_r <= 1'b0;
      error_r       <= 1'b0;
`ifdef UART_CMD_ECHO_EN
      write_uart_r  <= 1'b0;
      write_data_r  <= {DATA_BITS{1'b0}};
`endif
    end else begin
      state_r       <= state_nxt;
      byte_r        <= byte_nxt;
      acc_r         <= acc_nxt;
      count_r       <= count_nxt;
      discard_r     <= discard_nxt;
      read_uart_r   <= read_uart_nxt;
      value_r       <= value_nxt;
      value_valid_r <= value_valid_nxt;
      error_r       <= error_nxt;
`ifdef UART_CMD_ECHO_EN
      write_uart_r  <= write_uart_nxt;
      write_data_r  <= write_data_nxt;
`endif
    end
  end

  assign bus.ReadUart   = read_uart_r;
  assign bus.Value      = value_r;
  assign bus.ValueValid = value_valid_r;
  assign bus.Error      = error_r;

`ifdef UART_CMD_ECHO_EN
  assign bus.WriteUart  = write_uart_r;
  assign bus.WriteData  = write_data_r;
`else
  logic unused_tx_full_s;
  assign unused_tx_full_s = bus.TxFull;
  assign bus.WriteUart  = 1'b0;
  assign bus.WriteData  = {DATA_BITS{1'b0}};
`endif

endmodule

// File: tb/tb_uart_hex_cmd_parser.sv
// Scoreboard bench for uart_hex_cmd_parser: a FIFO model feeds bytes,
// stimulus queues expected Value/Error/echo events, a monitor compares.
module tb_uart_hex_cmd_parser;
  import uart_cmd_pkg::*;

`ifdef UART_CMD_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  typedef struct {
    bit          is_err;
    logic [15:0] value;
  } exp_t;

  logic Clock  = 1'b0;
  logic ResetN = 1'b0;

  uart_hex_cmd_parser_if #(.DATA_BITS(8), .VALUE_DIGITS(4)) bus ();

  uart_hex_cmd_parser #(.DATA_BITS(8), .VALUE_DIGITS(4)) dut (
    .Clock  (Clock),
    .ResetN (ResetN),
    .bus    (bus)
  );

  always #5 Clock = ~Clock;

  logic [7:0] rx_q[$];
  logic [7:0] echo_q[$];
  exp_t       exp_q[$];
  int checks = 0;
  int errors = 0;
  int rd_pulses = 0;
  int wr_pulses = 0;
  int vv_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RX FIFO model: pop on ReadUart, present head between clock edges
  initial begin
    bus.RxEmpty  = 1'b1;
    bus.ReadData = 8'h00;
    forever begin
      @(negedge Clock);
      if (bus.ReadUart === 1'b1 && rx_q.size() > 0) void'(rx_q.pop_front());
      if (rx_q.size() > 0) begin
        bus.RxEmpty  = 1'b0;
        bus.ReadData = rx_q[0];
      end else begin
        bus.RxEmpty  = 1'b1;
        bus.ReadData = 8'h00;
      end
    end
  end

  // Monitor: compare every strobe against the scoreboard queues
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      if (ResetN) begin
        if (bus.ReadUart === 1'b1) rd_pulses++;
        if (bus.ValueValid === 1'b1) vv_pulses++;
        if (bus.ValueValid === 1'b1 && bus.Error === 1'b1) begin
          checks++; errors++;
          $display("FAIL exclusive_strobes: ValueValid and Error both 1, required not both");
        end
        if (bus.ValueValid === 1'b1 || bus.Error === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_event: ValueValid=%0b Error=%0b Value=%h, required no event",
                     bus.ValueValid, bus.Error, bus.Value);
          end else begin
            e = exp_q.pop_front();
            if (e.is_err) begin
              check("event_is_error", {31'd0, bus.Error}, 32'd1);
            end else begin
              check("event_is_valid", {31'd0, bus.ValueValid}, 32'd1);
              check("event_value", {16'd0, bus.Value}, {16'd0, e.value});
            end
          end
        end
        if (bus.WriteUart === 1'b1) begin
          wr_pulses++;
          if (echo_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: WriteData=%h, required no WriteUart", bus.WriteData);
          end else begin
            check("echo_data", {24'd0, bus.WriteData}, {24'd0, echo_q.pop_front()});
          end
        end
      end
    end
  end

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(posedge Clock); #1;
      rx_q.push_back(s[i]);
      if (ECHO) echo_q.push_back(s[i]);
    end
  endtask

  task automatic expect_value(input logic [15:0] v);
    exp_t e;
    e.is_err = 1'b0;
    e.value  = v;
    exp_q.push_back(e);
  endtask

  task automatic expect_error();
    exp_t e;
    e.is_err = 1'b1;
    e.value  = 16'h0000;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((rx_q.size() != 0 || exp_q.size() != 0 || echo_q.size() != 0) && n < 300) begin
      @(posedge Clock);
      n++;
    end
    repeat (4) @(posedge Clock);
    #1;
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL %s_timeout: rx=%0d exp=%0d echo=%0d left, required all 0",
               name, rx_q.size(), exp_q.size(), echo_q.size());
      rx_q.delete(); exp_q.delete(); echo_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ReadUart"},   {31'd0, bus.ReadUart},   32'd0);
    check({tag, "_WriteUart"},  {31'd0, bus.WriteUart},  32'd0);
    check({tag, "_WriteData"},  {24'd0, bus.WriteData},  32'd0);
    check({tag, "_Value"},      {16'd0, bus.Value},      32'd0);
    check({tag, "_ValueValid"}, {31'd0, bus.ValueValid}, 32'd0);
    check({tag, "_Error"},      {31'd0, bus.Error},      32'd0);
  endtask

  // Directed stimulus sequence
  initial begin
    int r0, w0, v0;
    bus.TxFull = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    check_reset_outputs("reset");
    @(negedge Clock);
    ResetN = 1'b1;

    // "1A2f\r" -> 0x1A2F, five pops
    r0 = rd_pulses;
    expect_value(16'h1A2F);
    send("1A2f\r");
    wait_drain("t1");
    check("t1_pops", rd_pulses - r0, 32'd5);
    check("t1_value", {16'd0, bus.Value}, 32'h1A2F);

    // Empty line: nothing; then "7\r\n" -> one value
    send("\r\n");
    wait_drain("t2a");
    check("t2a_value_held", {16'd0, bus.Value}, 32'h1A2F);
    v0 = vv_pulses;
    expect_value(16'h0007);
    send("7\r\n");
    wait_drain("t2b");
    check("t2b_one_valid", vv_pulses - v0, 32'd1);
    check("t2b_value", {16'd0, bus.Value}, 32'h0007);

    // Overflow on fifth digit, value held; then recovery
    expect_error();
    send("12345\r");
    wait_drain("t3a");
    check("t3a_value_held", {16'd0, bus.Value}, 32'h0007);
    expect_value(16'hBEEF);
    send("BEEF\r");
    wait_drain("t3b");
    check("t3b_value", {16'd0, bus.Value}, 32'hBEEF);

    // Illegal character; then recovery
    expect_error();
    send("1G\r");
    wait_drain("t4a");
    check("t4a_value_held", {16'd0, bus.Value}, 32'hBEEF);
    expect_value(16'h00C0);
    send("C0\r");
    wait_drain("t4b");
    check("t4b_value", {16'd0, bus.Value}, 32'h00C0);

    // Tx back-pressure: with echo the parser stalls after the first byte
    bus.TxFull = 1'b1;
    r0 = rd_pulses;
    w0 = wr_pulses;
    expect_value(16'h000A);
    send("A\r");
    repeat (20) @(posedge Clock);
    #1;
    check("t5_pops_while_full", rd_pulses - r0, ECHO ? 32'd1 : 32'd2);
    check("t5_writes_while_full", wr_pulses - w0, 32'd0);
    bus.TxFull = 1'b0;
    wait_drain("t5");
    check("t5_writes_after", wr_pulses - w0, ECHO ? 32'd2 : 32'd0);
    check("t5_value", {16'd0, bus.Value}, 32'h000A);

    // Reset mid-line discards the partial "AB"
    send("AB");
    wait_drain("t6a");
    ResetN = 1'b0;
    @(negedge Clock);
    check_reset_outputs("t6_reset");
    @(negedge Clock);
    ResetN = 1'b1;
    v0 = vv_pulses;
    expect_value(16'h000C);
    send("C\r");
    wait_drain("t6b");
    check("t6_one_valid", vv_pulses - v0, 32'd1);
    check("t6_value", {16'd0, bus.Value}, 32'h000C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_hex_cmd_parser.md
# uart_hex_cmd_parser

Receive-side consumer for the UART block: pops bytes from the UART RX FIFO, parses ASCII hexadecimal command lines terminated by CR or LF, and presents the parsed number on a held output with a one-cycle valid strobe. It connects directly to the UART's `ReadUart`, `ReadData` and `RxEmpty`. With echo compiled in, it also drives `WriteUart`/`WriteData` so each received byte is returned on Tx.

## Interface
- `DATA_BITS`, 8, UART byte width; must be 8 for ASCII decode.
- `VALUE_DIGITS`, 4, maximum hex digits per command; `Value` width is 4*VALUE_DIGITS.
- `Clock`  in  1  system clock (CLOCK_50 domain).
- `ResetN`  in  1  reset, asynchronous, active-low; one clock, no other clock domains.
- `RxEmpty`  in  1  UART RX FIFO empty.
- `ReadData`  in  DATA_BITS  RX FIFO head; valid whenever RxEmpty=0.
- `ReadUart`  out  1  one-cycle pop of RX FIFO head.
- `TxFull`  in  1  UART TX FIFO full (echo only).
- `WriteUart`  out  1  one-cycle push to TX FIFO (echo only).
- `WriteData`  out  DATA_BITS  byte pushed to TX FIFO.
- `Value`  out  4*VALUE_DIGITS  last successfully parsed value; held until next success.
- `ValueValid`  out  1  one-cycle strobe: `Value` just updated.
- `Error`  out  1  one-cycle strobe: illegal character or digit overflow.

## Operation
- Registers: `Byte` (DATA_BITS), `Acc` (4*VALUE_DIGITS), `Count` (0..VALUE_DIGITS), `Discard` flag, state.
- States: IDLE, DECODE, ECHO (ECHO exists only with echo enabled).
- IDLE: if RxEmpty=0, latch `ReadData` into `Byte`, go to DECODE; else stay.
- DECODE: `ReadUart`=1 for this cycle only; classify `Byte`; then go to ECHO (echo on) or IDLE.
- Digit = 0x30-0x39, 0x41-0x46, 0x61-0x66, mapped to nibble 0-15.
- Digit, Discard=0, Count<VALUE_DIGITS: Acc <= {Acc[4*VALUE_DIGITS-5:0], nibble}; Count+1.
- Digit, Count=VALUE_DIGITS (overflow): Error strobe; Discard<=1; Acc, Count cleared.
- Digit while Discard=1: ignored, no further Error.
- Terminator 0x0D or 0x0A: if Discard=0 and Count>0, Value<=Acc and ValueValid strobe. Always clear Acc, Count, Discard. Empty line (Count=0) gives no strobe, so CRLF yields one value.
- Any other byte: Error strobe unless Discard=1 already; Discard<=1; Acc, Count cleared.
- ECHO: hold while TxFull=1; when TxFull=0, WriteUart=1 for one cycle with WriteData=Byte, then IDLE. No new RX byte is fetched while in ECHO.
- Reset values: ReadUart 0, WriteUart 0, WriteData 0, Value 0, ValueValid 0, Error 0, Acc 0, Count 0, Discard 0, state IDLE.
- Reset asserted mid-command discards the partial line; the next digits start a new value.

## Timing
- All outputs registered.
- Cycle t: IDLE samples RxEmpty=0 and latches Byte.
- Cycle t+1: DECODE, ReadUart=1.
- Cycle t+2: ValueValid/Error visible for exactly one cycle. State is IDLE (no echo) or ECHO.
- Without echo: IDLE at t+2 samples the post-pop RxEmpty, so a byte is never read twice. Max rate is one byte per 2 cycles.
- With echo: earliest WriteUart is at t+2 when TxFull=0. Next IDLE is at t+3.
- ValueValid and Error are never asserted in the same cycle.

## Configuration
- Macro `UART_CMD_ECHO_EN`.
- Defined: ECHO state present, behaviour as above.
- Undefined: no ECHO state; WriteUart tied 0; WriteData tied 0; TxFull unused; DECODE always returns to IDLE.

## Structure
- Package `uart_cmd_pkg` holds:
  - state enum;
  - ASCII constants (CR 0x0D, LF 0x0A, digit range bounds);
  - `NIBBLE_BITS`=4.
- Sub-module `ascii_hex_classifier` (combinational): byte in; IsDigit, IsTerm, Nibble out. Instantiated once in the parser.

## Test plan
- Push 0x31,0x41,0x32,0x66,0x0D ("1A2f\r"): 5 ReadUart pulses; one ValueValid; Value=0x1A2F; Error never high.
- Push "\r\n": no ValueValid, no Error. Then "7\r\n": exactly one ValueValid, Value=0x0007.
- Push "12345\r": Error pulse on '5', no ValueValid on CR, Value unchanged. Then "BEEF\r": Value=0xBEEF.
- Push "1G\r": one Error on 'G', no ValueValid. Then "C0\r": Value=0x00C0.
- Echo on, TxFull held 1 for 20 cycles after byte 0x41: WriteUart stays 0 and no second ReadUart. TxFull→0: one WriteUart with WriteData=0x41.
- Push "AB", pulse ResetN low mid-stream, then "C\r": all outputs return to reset values; Value=0x000C with one ValueValid.
